xor_frame_checker: RTL and testbench

Streaming XOR/parity accumulator. It takes WIDTH-bit words over a valid/ready handshake, folds each accepted word into a running bitwise XOR, and counts words per frame. At frame end (in_last, or MAX_WORDS reached) it presents the frame's XOR signature, a configurable-sense parity bit, the word count and an overflow flag on a second valid/ready handshake. It generalises the team's single-bit NAND-built XOR into a parametrised, clocked checker for data-integrity tests on word streams.

---
 rtl/xor_pkg.sv | 15 +
 rtl/xor_word.sv | 20 ++
 rtl/xor_frame_checker.sv | 128 ++++++++++++
 tb/tb_xor_frame_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/xor_pkg.sv
// Shared definitions for the XOR frame checker: FSM state encodings and the
// count-width helper.
package xor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xor_word.sv
// Bitwise XOR of two words, each bit built from the four-NAND XOR cell.
module xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic n1_s;
    logic n2_s;
    logic n3_s;
    assign n1_s   = ~(a_i[i] & b_i[i]);
    assign n2_s   = ~(a_i[i] & n1_s);
    assign n3_s   = ~(b_i[i] & n1_s);
    assign y_o[i] = ~(n2_s & n3_s);
  end

endmodule

// File: rtl/xor_frame_checker.sv
// Streaming XOR/parity accumulator: folds accepted words into a running XOR and
// presents a per-frame signature, parity, count and overflow flag.
module xor_frame_checker
  import xor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  parameter bit ODD       = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_xor,
  output logic                               out_parity,
  output logic [clog2p1(MAX_WORDS)-1:0]      out_count,
  output logic                               out_overflow
);

  localparam int CW = clog2p1(MAX_WORDS);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              parity_q, parity_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  xor_s;
  logic [CW-1:0]     count_inc_s;
  logic              hit_max_s;

  xor_word #(.WIDTH(WIDTH)) u_xor_word (
    .a_i (acc_q),
    .b_i (in_data),
    .y_o (xor_s)
  );

  assign count_inc_s = count_q + CW'(1);
  assign hit_max_s   = (count_inc_s == CW'(MAX_WORDS));

  // State and result registers; the accumulator doubles as the out_xor register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      parity_q   <= ODD;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      parity_q   <= parity_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and datapath update; nothing is accepted while a result is pending.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, ACC: begin
        if (in_valid) begin
          acc_d   = xor_s;
          count_d = count_inc_s;
          if (in_last || hit_max_s) begin
            state_d    = DONE;
            overflow_d = hit_max_s && !in_last;
          end else begin
            state_d    = ACC;
            overflow_d = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d    = IDLE;
          acc_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d    = IDLE;
        acc_d      = '0;
        count_d    = '0;
        overflow_d = 1'b0;
      end
    endcase
    parity_d = (^acc_d) ^ ODD;
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign out_xor      = acc_q;
  assign out_count    = count_q;
  assign out_parity   = parity_q;
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_xor_frame_checker.sv
// Directed scoreboard bench: dut0 (MAX_WORDS=4, even parity), dut1 (MAX_WORDS=1, odd parity).
module tb_xor_frame_checker;

  typedef struct packed {
    logic [7:0] x;
    logic       p;
    logic [2:0] c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, l0 = 1'b0, ordy0 = 1'b1;
  logic [7:0] d0 = 8'h00;
  logic       v1 = 1'b0, l1 = 1'b0, ordy1 = 1'b1;
  logic [7:0] d1 = 8'h00;
  logic       irdy0, ovld0, par0, ovf0;
  logic [7:0] x0;
  logic [2:0] cnt0;
  logic       irdy1, ovld1, par1, ovf1;
  logic [7:0] x1;
  logic [0:0] cnt1;

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  always #5 clk = ~clk;

  xor_frame_checker #(.WIDTH(8), .MAX_WORDS(4), .ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(irdy0), .in_data(d0), .in_last(l0),
    .out_valid(ovld0), .out_ready(ordy0), .out_xor(x0), .out_parity(par0),
    .out_count(cnt0), .out_overflow(ovf0)
  );

  xor_frame_checker #(.WIDTH(8), .MAX_WORDS(1), .ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(irdy1), .in_data(d1), .in_last(l1),
    .out_valid(ovld1), .out_ready(ordy1), .out_xor(x1), .out_parity(par1),
    .out_count(cnt1), .out_overflow(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic last);
    if (sel) begin v1 = 1'b1; d1 = d; l1 = last; end
    else     begin v0 = 1'b1; d0 = d; l0 = last; end
    step();
    v0 = 1'b0; l0 = 1'b0; v1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic push(input bit sel, input logic [7:0] x, input logic p,
                      input logic [2:0] c, input logic o);
    exp_t e;
    e = '{x: x, p: p, c: c, o: o};
    if (sel) exp_q1.push_back(e);
    else     exp_q0.push_back(e);
  endtask

  // Result must be present in the cycle right after the closing word was accepted.
  task automatic check_frame(input bit sel, input string tag);
    exp_t e;
    if ((sel ? exp_q1.size() : exp_q0.size()) == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = sel ? exp_q1.pop_front() : exp_q0.pop_front();
      chk({tag, "_valid"},  sel ? ovld1 : ovld0,               32'd1);
      chk({tag, "_inrdy"},  sel ? irdy1 : irdy0,               32'd0);
      chk({tag, "_xor"},    sel ? x1 : x0,                     e.x);
      chk({tag, "_parity"}, sel ? par1 : par0,                 e.p);
      chk({tag, "_count"},  sel ? {2'b00, cnt1} : cnt0,        e.c);
      chk({tag, "_ovf"},    sel ? ovf1 : ovf0,                 e.o);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_inrdy"}, irdy0, 32'd1);
    chk({tag, "_valid"}, ovld0, 32'd0);
    chk({tag, "_count"}, cnt0,  32'd0);
  endtask

  initial begin
    // Reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_inrdy", irdy0, 32'd1);
    chk("rst_valid", ovld0, 32'd0);
    chk("rst_xor",   x0,    32'h00);
    chk("rst_par",   par0,  32'd0);
    chk("rst_count", cnt0,  32'd0);
    chk("rst_ovf",   ovf0,  32'd0);
    chk("rst_par_odd", par1, 32'd1);

    // Normal frame, result consumed immediately
    ordy0 = 1'b1;
    send(1'b0, 8'h0F, 1'b0);
    send(1'b0, 8'hF0, 1'b0);
    push(1'b0, 8'hCC, 1'b0, 3'd3, 1'b0);
    send(1'b0, 8'h33, 1'b1);
    check_frame(1'b0, "normal");
    step();
    check_idle("normal_after");
    chk("normal_after_xor", x0, 32'h00);

    // Overflow without in_last, then the same words closed by in_last
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h04, 1'b0);
    push(1'b0, 8'h0F, 1'b0, 3'd4, 1'b1);
    send(1'b0, 8'h08, 1'b0);
    check_frame(1'b0, "ovf");
    step();
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h04, 1'b0);
    push(1'b0, 8'h0F, 1'b0, 3'd4, 1'b0);
    send(1'b0, 8'h08, 1'b1);
    check_frame(1'b0, "full_last");
    step();

    // Backpressure: result held, 0xFF offered but never absorbed
    ordy0 = 1'b0;
    send(1'b0, 8'h0F, 1'b0);
    send(1'b0, 8'hF0, 1'b0);
    push(1'b0, 8'hCC, 1'b0, 3'd3, 1'b0);
    send(1'b0, 8'h33, 1'b1);
    check_frame(1'b0, "bp");
    v0 = 1'b1; d0 = 8'hFF; l0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", ovld0, 32'd1);
      chk("bp_hold_inrdy", irdy0, 32'd0);
      chk("bp_hold_xor",   x0,    32'hCC);
      chk("bp_hold_count", cnt0,  32'd3);
    end
    v0 = 1'b0; l0 = 1'b0;
    ordy0 = 1'b1;
    step();
    check_idle("bp_release");
    push(1'b0, 8'h55, 1'b0, 3'd1, 1'b0);
    send(1'b0, 8'h55, 1'b1);
    check_frame(1'b0, "bp_next");
    step();

    // Reset mid-frame discards the partial frame
    send(1'b0, 8'hAA, 1'b0);
    send(1'b0, 8'h11, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midrst");
    chk("midrst_xor", x0, 32'h00);
    push(1'b0, 8'hAA, 1'b0, 3'd1, 1'b0);
    send(1'b0, 8'hAA, 1'b1);
    check_frame(1'b0, "midrst_frame");
    step();

    // Odd parity, MAX_WORDS=1: every word closes its frame
    push(1'b1, 8'h01, 1'b0, 3'd1, 1'b0);
    send(1'b1, 8'h01, 1'b1);
    check_frame(1'b1, "odd_last");
    step();
    chk("odd_after_inrdy", irdy1, 32'd1);
    push(1'b1, 8'h03, 1'b1, 3'd1, 1'b1);
    send(1'b1, 8'h03, 1'b0);
    check_frame(1'b1, "odd_ovf");
    step();
    chk("odd_ovf_after_valid", ovld1, 32'd0);

    chk("queues_drained", exp_q0.size() + exp_q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
